stream_seq_source: RTL and testbench

Transmit-side partner of the single-stage valid/ready pipeline register. On a start command it generates a burst of `length` data beats forming an arithmetic sequence (`start_value`, `+step`, …) and drives them onto a valid/ready output port that connects directly to the register's input side. It honours backpressure, can insert a programmable idle gap between beats, and reports progress via `busy`, a `done` pulse and a beat counter. It serves as traffic generator and bring-up stimulus source for stream paths.

---
 rtl/stream_seq_source_if.sv | 21 ++
 rtl/stream_seq_source.sv | 121 ++++++++++++
 tb/tb_stream_seq_source.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_seq_source_if.sv
// Valid/ready stream port carrying one DATA_W beat per handshake.
// The master drives valid/data and the slave drives ready.
interface stream_seq_source_if #(
  parameter int DATA_W = 8
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/stream_seq_source.sv
// Burst generator that emits an arithmetic sequence on a valid/ready stream.
// Supports backpressure, a programmable idle gap between beats, and busy/done/beat-count status.
module stream_seq_source #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     start_value,
  input  logic [DATA_W-1:0]     step,
  input  logic [LEN_W-1:0]      length,
  input  logic [3:0]            gap,
  stream_seq_source_if.master   out,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      beat_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Sequence values wrap modulo 2^DATA_W; there is deliberately no saturation.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] cur_q,      cur_d;
  logic [LEN_W-1:0]  rem_q,      rem_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]        gap_cnt_q,  gap_cnt_d;
  logic [DATA_W-1:0] step_q,     step_d;
  logic [3:0]        gap_cfg_q,  gap_cfg_d;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    step_d     = step_q;
    gap_cfg_d  = gap_cfg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d     = step;
          gap_cfg_d  = gap;
          cur_d      = start_value;
          rem_d      = length;
          beat_cnt_d = '0;
          state_d    = (length != '0) ? S_SEND : S_DONE;
        end
      end

      S_SEND: begin
        if (out.out_ready) begin
          cur_d      = wrap_add(cur_q, step_q);
          rem_d      = rem_q - LEN_W'(1);
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_cfg_q != 4'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cfg_q;
          end
        end
      end

      // Counter starts at gap and releases on 1, giving exactly gap idle cycles.
      S_GAP: begin
        if (gap_cnt_q == 4'd1) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Burst configuration is only consumed outside IDLE, after a start has loaded it.
  always_ff @(posedge clk) begin
    step_q    <= step_d;
    gap_cfg_q <= gap_cfg_d;
  end

  assign out.out_valid = (state_q == S_SEND);
  assign out.out_data  = cur_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign beat_count    = beat_cnt_q;

endmodule

// File: tb/tb_stream_seq_source.sv
// Self-checking bench for stream_seq_source: randomized bursts checked against a
// sequence/timing reference derived from start value, step, length and gap.
module tb_stream_seq_source;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [DATA_W-1:0] start_value;
  logic [DATA_W-1:0] step;
  logic [LEN_W-1:0]  length;
  logic [3:0]        gap;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  beat_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_seq_source_if #(.DATA_W(DATA_W)) sif ();

  stream_seq_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_value (start_value),
    .step        (step),
    .length      (length),
    .gap         (gap),
    .out         (sif.master),
    .busy        (busy),
    .done        (done),
    .beat_count  (beat_count)
  );

  // Runs one burst starting at the current negedge. rmode: 0 ready always 1,
  // 1 ready pattern 1,0,0,1,0,1..., 2 random ready. poke pulses start with junk config mid-burst.
  task automatic run_burst(input logic [7:0] sv, input logic [7:0] st, input int len,
                           input int g, input int rmode, input bit poke);
    logic [7:0] exp_q[$];
    bit         pat[6];
    int         k, c, last_x, budget, rise_c;
    bit         prev_v, prev_r, fin, r;
    logic [7:0] prev_d;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < len; i++)
      exp_q.push_back(8'((int'(sv) + i * int'(st)) & 255));
    start_value = sv; step = st; length = len[7:0]; gap = g[3:0]; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    c = 1; k = 0; last_x = 0; prev_v = 0; prev_r = 0; prev_d = '0; fin = 0;
    budget = (len + 1) * (g + 2) * 8 + 40;
    while (!fin && c <= budget) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = pat[c % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = r;
      if (poke && c == 2) begin
        start = 1'b1; start_value = 8'($urandom); step = 8'($urandom);
        length = 8'($urandom); gap = 4'($urandom);
      end else if (poke && c == 3) begin
        start = 1'b0;
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL busy_in_burst: cycle %0d got %b want 1", c, busy);
      end
      if (prev_v && !prev_r) begin
        total++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== prev_d) begin
          bad++;
          $display("FAIL stall_hold: cycle %0d got v=%b d=%0h want v=1 d=%0h",
                   c, sif.out_valid, sif.out_data, prev_d);
        end
      end
      if (sif.out_valid === 1'b1 && !prev_v) begin
        rise_c = (k == 0) ? 1 : last_x + g + 1;
        total++;
        if (c != rise_c) begin
          bad++; $display("FAIL valid_rise: got cycle %0d want cycle %0d (beat %0d)", c, rise_c, k);
        end
      end
      if (sif.out_valid === 1'b1 && r) begin
        total++;
        if (k >= len) begin
          bad++; $display("FAIL extra_beat: got beat %0d want at most %0d beats", k + 1, len);
        end else if (sif.out_data !== exp_q[k]) begin
          bad++; $display("FAIL beat_data[%0d]: got %0h want %0h", k, sif.out_data, exp_q[k]);
        end
        last_x = c;
        k++;
      end
      if (done === 1'b1) begin
        total++;
        if (k != len || c != last_x + 1 || sif.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL done_timing: got beats=%0d cycle=%0d v=%b want beats=%0d cycle=%0d v=0",
                   k, c, sif.out_valid, len, last_x + 1);
        end
        fin = 1;
      end
      prev_v = (sif.out_valid === 1'b1);
      prev_r = r;
      prev_d = sif.out_data;
      if (!fin) begin
        @(posedge clk); @(negedge clk);
        c++;
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL burst_timeout: got no done after %0d cycles want done", budget);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.out_valid !== 1'b0 || beat_count !== len[7:0]) begin
      bad++;
      $display("FAIL idle_after_done: got busy=%b done=%b v=%b cnt=%0d want 0 0 0 cnt=%0d",
               busy, done, sif.out_valid, beat_count, len);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; start_value = '0; step = '0; length = '0; gap = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        beat_count !== 8'd0 || sif.out_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b busy=%b done=%b cnt=%0d d=%0h want all 0",
               sif.out_valid, busy, done, beat_count, sif.out_data);
    end
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_burst(8'h10, 8'h01, 4, 0, 0, 0);
    total++;
    if (beat_count !== 8'd4) begin
      bad++; $display("FAIL basic_count: got %0d want 4", beat_count);
    end
  endtask

  task automatic test_wrap_gap();
    run_burst(8'hFE, 8'h03, 3, 2, 0, 0);
    run_burst(8'h80, 8'hC1, 4, 15, 0, 0);
  endtask

  task automatic test_backpressure();
    run_burst(8'h20, 8'h05, 5, 0, 1, 0);
    run_burst(8'h40, 8'hFF, 5, 1, 1, 0);
  endtask

  task automatic test_zero_len_and_ignored_start();
    run_burst(8'h99, 8'h01, 0, 3, 0, 0);
    run_burst(8'h30, 8'h07, 6, 1, 0, 1);
    run_burst(8'h31, 8'h02, 4, 0, 2, 1);
  endtask

  task automatic test_back_to_back();
    run_burst(8'h01, 8'h01, 3, 0, 0, 0);
    run_burst(8'hF0, 8'h08, 3, 0, 0, 0);
  endtask

  task automatic test_max_len();
    run_burst(8'h00, 8'h01, 255, 0, 0, 0);
    total++;
    if (beat_count !== 8'hFF) begin
      bad++; $display("FAIL max_len_count: got %0d want 255", beat_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_burst(8'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 3)), 2, 0);
  endtask

  task automatic test_async_reset();
    start_value = 8'h55; step = 8'h02; length = 8'd5; gap = 4'd0; start = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    sif.out_ready = 1'b0;
    total++;
    if (sif.out_valid !== 1'b1 || beat_count !== 8'd1 || sif.out_data !== 8'h57) begin
      bad++;
      $display("FAIL pre_reset: got v=%b cnt=%0d d=%0h want v=1 cnt=1 d=57",
               sif.out_valid, beat_count, sif.out_data);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        beat_count !== 8'd0 || sif.out_data !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b busy=%b done=%b cnt=%0d d=%0h want all 0",
               sif.out_valid, busy, done, beat_count, sif.out_data);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_burst(8'hA0, 8'h10, 2, 1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_gap();
    test_backpressure();
    test_zero_len_and_ignored_start();
    test_back_to_back();
    test_max_len();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
